// File: rtl/mem_stage.sv
// MEM pipeline stage: data-bus load/store sequencing with LL/SC handling.
// Most outputs are combinational so that non-memory ops pass through with no added latency.
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef RESET_ENABLE
`define RESET_ENABLE 1'b1
`endif
`ifndef NOSTOP
`define NOSTOP 1'b0
`endif
`ifndef STOP
`define STOP 1'b1
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h00000000
`endif
`ifndef NOPRegAddr
`define NOPRegAddr 5'b00000
`endif
`ifndef EXE_LB_OP
`define EXE_LB_OP  8'b11100000
`define EXE_LBU_OP 8'b11100100
`define EXE_LH_OP  8'b11100001
`define EXE_LHU_OP 8'b11100101
`define EXE_LW_OP  8'b11100011
`define EXE_LL_OP  8'b11110000
`define EXE_SB_OP  8'b11101000
`define EXE_SH_OP  8'b11101001
`define EXE_SW_OP  8'b11101011
`define EXE_SC_OP  8'b11111000
`endif

module mem_stage (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [`RegAddrBus] waddr_i,
  input  logic [`RegBus]    wdata_i,
  input  logic              whilo_i,
  input  logic [`RegBus]    hi_i,
  input  logic [`RegBus]    lo_i,
  input  logic [`AluOpBus]  aluop_i,
  input  logic [`RegBus]    mem_addr_i,
  input  logic [`RegBus]    reg2_i,
  input  logic              LLbit_i,
  input  logic              wb_LLbit_we,
  input  logic              wb_LLbit_value,
  input  logic [`StallBus]  stall,
  output logic              stallreq,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [`RegBus]    bus_addr,
  output logic [`RegBus]    bus_wdata,
  input  logic              bus_ack,
  input  logic [`RegBus]    bus_rdata,
  output logic              mem_we,
  output logic [`RegAddrBus] mem_waddr,
  output logic [`RegBus]    mem_wdata,
  output logic              mem_whilo,
  output logic [`RegBus]    mem_hi,
  output logic [`RegBus]    mem_lo,
  output logic              mem_LLbit_we,
  output logic              mem_LLbit_value
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t         state;
  logic [`RegBus] rdata;

  logic is_load, is_store, is_byte, is_half, is_sc, is_ll;
  logic llbit_eff, access, requesting;
  logic [3:0]     sel;
  logic [`RegBus] store_data, load_data;
  logic [7:0]     rbyte;
  logic [15:0]    rhalf;

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  // Decode the memory op class and access size.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    case (aluop_i)
      `EXE_LB_OP, `EXE_LBU_OP: begin is_load = 1'b1; is_byte = 1'b1; end
      `EXE_LH_OP, `EXE_LHU_OP: begin is_load = 1'b1; is_half = 1'b1; end
      `EXE_LW_OP, `EXE_LL_OP:  is_load = 1'b1;
      `EXE_SB_OP: begin is_store = 1'b1; is_byte = 1'b1; end
      `EXE_SH_OP: begin is_store = 1'b1; is_half = 1'b1; end
      `EXE_SW_OP, `EXE_SC_OP:  is_store = 1'b1;
      default: ;
    endcase
  end

  assign is_sc      = (aluop_i == `EXE_SC_OP);
  assign is_ll      = (aluop_i == `EXE_LL_OP);
  assign llbit_eff  = wb_LLbit_we ? wb_LLbit_value : LLbit_i;
  assign access     = (is_load || is_store) && !(is_sc && !llbit_eff);
  assign requesting = ((state == IDLE) && access) || (state == WAIT);

  // Big-endian lane select, store replication and load extraction.
  always_comb begin
    if (is_byte)      sel = 4'b1000 >> mem_addr_i[1:0];
    else if (is_half) sel = mem_addr_i[1] ? 4'b0011 : 4'b1100;
    else              sel = 4'b1111;

    if (is_byte)      store_data = {4{reg2_i[7:0]}};
    else if (is_half) store_data = {2{reg2_i[15:0]}};
    else              store_data = reg2_i;

    case (mem_addr_i[1:0])
      2'b00:   rbyte = rdata[31:24];
      2'b01:   rbyte = rdata[23:16];
      2'b10:   rbyte = rdata[15:8];
      default: rbyte = rdata[7:0];
    endcase
    rhalf = mem_addr_i[1] ? rdata[15:0] : rdata[31:16];

    case (aluop_i)
      `EXE_LB_OP:  load_data = {{24{rbyte[7]}}, rbyte};
      `EXE_LBU_OP: load_data = {24'h000000, rbyte};
      `EXE_LH_OP:  load_data = {{16{rhalf[15]}}, rhalf};
      `EXE_LHU_OP: load_data = {16'h0000, rhalf};
      default:     load_data = rdata;
    endcase
  end

  // State and read-data capture; ack only matters while a request is out.
  always_ff @(posedge clk) begin
    if (rst == `RESET_ENABLE) begin
      state <= IDLE;
      rdata <= `ZERO_WORD;
    end else begin
      case (state)
        IDLE: begin
          if (access && bus_ack) begin
            state <= DONE;
            rdata <= bus_rdata;
          end else if (access) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus_ack) begin
            state <= DONE;
            rdata <= bus_rdata;
          end
        end
        DONE: begin
          if (stall[4] == `NOSTOP) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output steering.
  always_comb begin
    stallreq        = 1'b0;
    bus_req         = 1'b0;
    bus_we          = 1'b0;
    bus_sel         = 4'b0000;
    bus_addr        = `ZERO_WORD;
    bus_wdata       = `ZERO_WORD;
    mem_we          = we_i;
    mem_waddr       = waddr_i;
    mem_wdata       = wdata_i;
    mem_whilo       = whilo_i;
    mem_hi          = hi_i;
    mem_lo          = lo_i;
    mem_LLbit_we    = 1'b0;
    mem_LLbit_value = 1'b0;
    if (rst == `RESET_ENABLE) begin
      mem_we    = 1'b0;
      mem_waddr = `NOPRegAddr;
      mem_wdata = `ZERO_WORD;
      mem_whilo = 1'b0;
      mem_hi    = `ZERO_WORD;
      mem_lo    = `ZERO_WORD;
    end else if (requesting) begin
      stallreq  = 1'b1;
      bus_req   = 1'b1;
      bus_we    = is_store;
      bus_sel   = sel;
      bus_addr  = {mem_addr_i[31:2], 2'b00};
      bus_wdata = is_store ? store_data : `ZERO_WORD;
      mem_we    = 1'b0;
      mem_whilo = 1'b0;
    end else if (state == DONE) begin
      if (is_load) mem_wdata = load_data;
      if (is_ll) begin
        mem_LLbit_we    = 1'b1;
        mem_LLbit_value = 1'b1;
      end
      if (is_sc) begin
        mem_wdata       = 32'(1);
        mem_LLbit_we    = 1'b1;
        mem_LLbit_value = 1'b0;
      end
    end else if (is_sc) begin
      // SC whose link was lost: report failure without touching the bus.
      mem_wdata = `ZERO_WORD;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus queues expected outputs, a negedge monitor checks them.
module tb_mem_stage;

  localparam logic [7:0] OP_ADDU = 8'b00100001;
  localparam logic [7:0] OP_LB   = 8'b11100000;
  localparam logic [7:0] OP_LBU  = 8'b11100100;
  localparam logic [7:0] OP_LH   = 8'b11100001;
  localparam logic [7:0] OP_LHU  = 8'b11100101;
  localparam logic [7:0] OP_LW   = 8'b11100011;
  localparam logic [7:0] OP_LL   = 8'b11110000;
  localparam logic [7:0] OP_SB   = 8'b11101000;
  localparam logic [7:0] OP_SH   = 8'b11101001;
  localparam logic [7:0] OP_SW   = 8'b11101011;
  localparam logic [7:0] OP_SC   = 8'b11111000;

  logic clk, rst;
  logic we_i, whilo_i, LLbit_i, wb_LLbit_we, wb_LLbit_value, bus_ack;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i, hi_i, lo_i, mem_addr_i, reg2_i, bus_rdata;
  logic [7:0]  aluop_i;
  logic [5:0]  stall;
  logic stallreq, bus_req, bus_we, mem_we, mem_whilo, mem_LLbit_we, mem_LLbit_value;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata, mem_wdata, mem_hi, mem_lo;
  logic [4:0]  mem_waddr;

  mem_stage dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .LLbit_i(LLbit_i),
    .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value), .stall(stall),
    .stallreq(stallreq), .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_LLbit_we(mem_LLbit_we),
    .mem_LLbit_value(mem_LLbit_value)
  );

  typedef struct packed {
    logic        stallreq;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic        ll_we;
    logic        ll_val;
  } obs_t;

  obs_t  act;
  obs_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;

  assign act = {stallreq, bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
                mem_we, mem_waddr, mem_wdata, mem_whilo, mem_LLbit_we, mem_LLbit_value};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic sr, input logic br, input logic bwe,
                              input logic [3:0] sel, input logic [31:0] baddr,
                              input logic [31:0] bwd, input logic mwe, input logic [4:0] mwa,
                              input logic [31:0] mwd, input logic mwhilo,
                              input logic llwe, input logic llval);
    return {sr, br, bwe, sel, baddr, bwd, mwe, mwa, mwd, mwhilo, llwe, llval};
  endfunction

  // Request cycle: stall + bus request, writebacks suppressed (wdata_i kept 0 for mem ops).
  function automatic obs_t req(input logic bwe, input logic [3:0] sel,
                               input logic [31:0] baddr, input logic [31:0] bwd);
    return mk(1'b1, 1'b1, bwe, sel, baddr, bwd, 1'b0, 5'd5, 32'h0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic obs_t done(input logic [31:0] d, input logic llwe, input logic llval);
    return mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 5'd5, d, 1'b0, llwe, llval);
  endfunction

  task automatic push(input string n, input obs_t e);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whatever expectation the stimulus queued for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h", n, act, e);
      end
    end
  end

  task automatic load_ack(input string n, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] rd, input logic [3:0] sel,
                          input logic [31:0] d, input logic llwe, input logic llval);
    step;
    aluop_i = op; mem_addr_i = addr; bus_ack = 1'b1; bus_rdata = rd;
    push({n, "_req"}, req(1'b0, sel, {addr[31:2], 2'b00}, 32'h0));
    step;
    bus_ack = 1'b0; bus_rdata = 32'hDEADBEEF;
    push({n, "_done"}, done(d, llwe, llval));
  endtask

  task automatic store_ack(input string n, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] r2, input logic [3:0] sel, input logic [31:0] bwd,
                           input logic [31:0] d, input logic llwe, input logic llval);
    step;
    aluop_i = op; mem_addr_i = addr; reg2_i = r2; bus_ack = 1'b1;
    push({n, "_req"}, req(1'b1, sel, {addr[31:2], 2'b00}, bwd));
    step;
    bus_ack = 1'b0;
    push({n, "_done"}, done(d, llwe, llval));
  endtask

  initial begin
    rst = 1'b1; we_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'h0; whilo_i = 1'b0;
    hi_i = 32'h0; lo_i = 32'h0; aluop_i = OP_ADDU; mem_addr_i = 32'h0; reg2_i = 32'h0;
    LLbit_i = 1'b0; wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0; stall = 6'b0;
    bus_ack = 1'b0; bus_rdata = 32'h0;

    step;
    wdata_i = 32'h1234;
    push("reset", mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0));

    step;
    rst = 1'b0; whilo_i = 1'b1;
    push("addu", mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 5'd5, 32'h1234, 1, 0, 0));

    // LB with ack on the third WAIT cycle.
    step;
    whilo_i = 1'b0; wdata_i = 32'h0; aluop_i = OP_LB; mem_addr_i = 32'h103;
    push("lb_idle", req(1'b0, 4'b0001, 32'h100, 32'h0));
    step; push("lb_wait1", req(1'b0, 4'b0001, 32'h100, 32'h0));
    step; push("lb_wait2", req(1'b0, 4'b0001, 32'h100, 32'h0));
    step;
    bus_ack = 1'b1; bus_rdata = 32'h000000F0;
    push("lb_wait3", req(1'b0, 4'b0001, 32'h100, 32'h0));
    step;
    bus_ack = 1'b0; bus_rdata = 32'hDEADBEEF;
    push("lb_done", done(32'hFFFFFFF0, 1'b0, 1'b0));

    store_ack("sh", OP_SH, 32'h202, 32'hABCD1234, 4'b0011, 32'h12341234, 32'h0, 1'b0, 1'b0);
    load_ack("lbu", OP_LBU, 32'h101, 32'h12F03456, 4'b0100, 32'h000000F0, 1'b0, 1'b0);
    load_ack("lh", OP_LH, 32'h200, 32'h80017777, 4'b1100, 32'hFFFF8001, 1'b0, 1'b0);
    load_ack("lhu", OP_LHU, 32'h203, 32'h55558001, 4'b0011, 32'h00008001, 1'b0, 1'b0);
    load_ack("lw", OP_LW, 32'h47, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b0);
    store_ack("sb", OP_SB, 32'h102, 32'h1122335A, 4'b0010, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b0);
    store_ack("sw", OP_SW, 32'h10, 32'h89ABCDEF, 4'b1111, 32'h89ABCDEF, 32'h0, 1'b0, 1'b0);
    load_ack("ll", OP_LL, 32'h80, 32'h0BADCAFE, 4'b1111, 32'h0BADCAFE, 1'b1, 1'b1);

    // SC succeeds only through the forwarded LLbit.
    LLbit_i = 1'b0; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    store_ack("sc_ok", OP_SC, 32'h80, 32'h13572468, 4'b1111, 32'h13572468, 32'h1, 1'b1, 1'b0);

    step;
    wb_LLbit_we = 1'b0; aluop_i = OP_SC; mem_addr_i = 32'h300; reg2_i = 32'h24681357;
    push("sc_fail", mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 5'd5, 32'h0, 0, 0, 0));
    step;
    LLbit_i = 1'b1; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b0;
    push("sc_fwd_clear", mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 5'd5, 32'h0, 0, 0, 0));

    // Reset while waiting on the bus; the late ack must not be acted on.
    step;
    LLbit_i = 1'b0; wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0;
    aluop_i = OP_LW; mem_addr_i = 32'h500;
    push("rst_lw_idle", req(1'b0, 4'b1111, 32'h500, 32'h0));
    step; push("rst_lw_wait", req(1'b0, 4'b1111, 32'h500, 32'h0));
    step;
    rst = 1'b1;
    push("rst_mid", mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0));
    step;
    rst = 1'b0; aluop_i = OP_ADDU; wdata_i = 32'h77; bus_ack = 1'b1; bus_rdata = 32'h99;
    push("late_ack", mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 5'd5, 32'h77, 0, 0, 0));
    step;
    bus_ack = 1'b0;
    push("post_rst", mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 5'd5, 32'h77, 0, 0, 0));

    // LW held in DONE by stall[4]; acks during DONE are ignored.
    step;
    wdata_i = 32'h0; aluop_i = OP_LW; mem_addr_i = 32'h600; bus_ack = 1'b1;
    bus_rdata = 32'h600DF00D; stall = 6'b011111;
    push("stall_req", req(1'b0, 4'b1111, 32'h600, 32'h0));
    step;
    bus_rdata = 32'h0;
    push("stall_done1", done(32'h600DF00D, 1'b0, 1'b0));
    step; push("stall_done2", done(32'h600DF00D, 1'b0, 1'b0));
    step;
    stall = 6'b0;
    push("stall_release", done(32'h600DF00D, 1'b0, 1'b0));
    step;
    bus_ack = 1'b0; aluop_i = OP_ADDU; wdata_i = 32'h55;
    push("after_stall", mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 5'd5, 32'h55, 0, 0, 0));

    step;
    step;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have no parameters; widths come from the shared `RegBus`, `RegAddrBus`, `AluOpBus` and `StallBus` defines.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous and active-high (`RESET_ENABLE`).
REQ-004 we_i, waddr_i, wdata_i  in  1/`RegAddrBus`/`RegBus`  GPR write request from the EX/MEM latch.
REQ-005 whilo_i, hi_i, lo_i  in  1/`RegBus`/`RegBus`  HI/LO write request from the EX/MEM latch.
REQ-006 aluop_i  in  `AluOpBus`  operation code; `EXE_{LB,LBU,LH,LHU,LW,LL,SB,SH,SW,SC}_OP` are memory ops, all other codes are non-memory.
REQ-007 mem_addr_i, reg2_i  in  `RegBus`  effective address; store data (rt).
REQ-008 LLbit_i  in  1  current LLbit register value.
REQ-009 wb_LLbit_we, wb_LLbit_value  in  1/1  LLbit write pending in WB, used for forwarding.
REQ-010 stall  in  `StallBus`  ctrl stall vector; stall[4] is this stage.
REQ-011 stallreq  out  1  stall request to ctrl.
REQ-012 bus_req, bus_we, bus_sel, bus_addr, bus_wdata  out  1/1/4/`RegBus`/`RegBus`  data-bus request.
REQ-013 bus_ack, bus_rdata  in  1/`RegBus`  data-bus completion and read data.
REQ-014 mem_we, mem_waddr, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_LLbit_we, mem_LLbit_value  out  toward MEM/WB, same widths as the corresponding inputs.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-016 Non-memory op in IDLE: all outputs SHALL pass through combinationally, with zero latency, stallreq=0 and bus_req=0.
REQ-017 Memory op in IDLE, except a failing SC (REQ-024): bus_req=1 and stallreq=1 the same cycle; the next state SHALL be DONE if bus_ack=1, else WAIT.
REQ-018 WAIT: bus_req=1 and stallreq=1 are held, with bus_addr/we/sel/wdata stable; bus_ack=1 -> DONE.
REQ-019 On the ack edge the block SHALL latch bus_rdata into an internal rdata register.
REQ-020 DONE: bus_req=0 and stallreq=0, and results are produced from the latched rdata.
- Next state SHALL be IDLE when stall[4]==`NOSTOP`, else the block remains in DONE.
- bus_ack SHALL be ignored whenever bus_req=0.
REQ-021 While a memory op is in IDLE or WAIT, mem_we, mem_whilo and mem_LLbit_we SHALL be 0.
REQ-022 Byte lanes are big-endian.
- Byte ops: mem_addr_i[1:0]=00/01/10/11 -> bus_sel 1000/0100/0010/0001, data lane [31:24]/[23:16]/[15:8]/[7:0].
- Halfword ops: addr[1]=0 -> sel 1100 [31:16]; addr[1]=1 -> sel 0011 [15:0]; addr[0] is ignored.
- Word ops: sel 1111.
- bus_addr SHALL be {mem_addr_i[31:2],2'b00}.
REQ-023 Loads: LB/LH sign-extend, LBU/LHU zero-extend, and LW/LL pass the full word.
- Stores: bus_we=1, with reg2_i byte/halfword replicated across all lanes.
REQ-024 The effective LLbit SHALL be wb_LLbit_value if wb_LLbit_we=1, else LLbit_i.
REQ-025 LL in DONE: mem_LLbit_we=1 and mem_LLbit_value=1.
REQ-026 SC with effective LLbit=1: performs a word store via REQ-017..020.
- In DONE: mem_wdata=1, mem_LLbit_we=1, mem_LLbit_value=0.
REQ-027 SC with effective LLbit=0: no bus access, stallreq=0, zero latency; mem_wdata=0 and mem_LLbit_we=0.
REQ-028 Loads in DONE SHALL drive mem_we=we_i; stores and SC SHALL pass we_i unchanged.

Reset
REQ-029 rst=1 at a posedge SHALL force state IDLE and clear the rdata register to `ZERO_WORD`.
- This includes reset arriving mid-transaction in WAIT or DONE; the outstanding ack is dropped.
REQ-030 While rst=1 the following outputs SHALL be driven to 0 / `ZERO_WORD` / `NOPRegAddr`:
- stallreq, bus_req, bus_we, bus_sel, bus_addr, bus_wdata
- mem_we, mem_waddr, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_LLbit_we, mem_LLbit_value

Verification
REQ-031 ADDU, waddr=5, wdata=0x1234: the same cycle shows mem_we=1, mem_wdata=0x1234, stallreq=0 and bus_req=0.
REQ-032 LB at addr 0x103, bus_rdata=0x000000F0, ack after 3 WAIT cycles: stallreq high for 4 cycles; then DONE with sel 0001 and mem_wdata=0xFFFFFFF0.
REQ-033 SH at addr 0x202, reg2_i=0xABCD1234, same-cycle ack: bus_sel=0011, bus_wdata=0x12341234, bus_we=1; DONE on the next cycle.
REQ-034 LLbit_i=0 with wb_LLbit_we=1, wb_LLbit_value=1, SC: bus store occurs, then mem_wdata=1, mem_LLbit_we=1, mem_LLbit_value=0.
- Repeat with wb_LLbit_we=0: no bus_req, mem_wdata=0.
REQ-035 LW, rst asserted in WAIT: next cycle state IDLE, bus_req=0, stallreq=0; a late ack is ignored.
REQ-036 LW reaches DONE with stall[4] held `STOP` for 2 cycles: the block remains in DONE with no new bus_req, then returns to IDLE once stall[4]=`NOSTOP`.
